sram_bus_responder: RTL and testbench

Bus responder that serves the CPU bus window 0x0000-0x8FFF from an external asynchronous 8-bit SRAM, replacing the block-RAM stand-in.
- Receives the CPU's read-request / write-enable initiator signals and the registered chip-select.
- Sequences the SRAM control strobes with programmable wait states.
- Throttles the CPU through `ready`.
- Returns read data on the shared read-data mux.

---
 rtl/sram_bus_responder_pkg.sv | 33 +++
 rtl/sram_bus_responder.sv | 194 +++++++++++++++++++
 tb/tb_sram_bus_responder.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bus_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_bus_responder_pkg                                       |
// | Description : Shared definitions for the external-SRAM bus responder:      |
// |               state encodings, default wait-state count and the CPU bus    |
// |               window decode (0x0000-0x8FFF) shared with the top decoder.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sram_bus_responder_pkg;

   typedef enum logic [2:0] {
      SRAM_IDLE       = 3'd0,
      SRAM_RD_ACCESS  = 3'd1,
      SRAM_RD_CAPTURE = 3'd2,
      SRAM_WR_SETUP   = 3'd3,
      SRAM_WR_PULSE   = 3'd4,
      SRAM_WR_HOLD    = 3'd5
   } sram_state_e;

   // Strobe width in cycles for the fitted SRAM part.
   localparam int SRAM_WAIT_DEFAULT = 2;

   // CPU window served by the external SRAM.
   localparam logic [15:0] SRAM_WIN_BASE = 16'h0000;
   localparam logic [15:0] SRAM_WIN_LAST = 16'h8FFF;

   // Offset compare keeps the test valid if the window base ever moves off 0.
   function automatic logic sram_win_hit(input logic [15:0] addr);
      return (addr - SRAM_WIN_BASE) <= (SRAM_WIN_LAST - SRAM_WIN_BASE);
   endfunction

endpackage : sram_bus_responder_pkg
`default_nettype wire

// File: rtl/sram_bus_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_bus_responder                                           |
// | Description : Serves CPU bus reads/writes from an external asynchronous    |
// |               SRAM with WAIT_CYCLES-wide strobes, stalling the CPU via     |
// |               ready while an access is in flight.                          |
// | Ports       : sys_clk/reset_n     clock, synchronous active-low reset      |
// |               cs, bus_addr        window select and CPU address            |
// |               bus_rd_req          read request level (rising edge starts)  |
// |               bus_wr_en/_wr_data  one-cycle write strobe and data          |
// |               bus_rd_data         registered read data                     |
// |               ready               0 = CPU must stall                       |
// |               err_overrun         sticky: request arrived while busy       |
// |               sram_*              SRAM address, dq pad and strobes         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sram_bus_responder
   import sram_bus_responder_pkg::*;
#(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 8,
   parameter int WAIT_CYCLES = SRAM_WAIT_DEFAULT   // legal 1..15
) (
   input  logic                  sys_clk,
   input  logic                  reset_n,
   input  logic                  cs,
   input  logic [ADDR_WIDTH-1:0] bus_addr,
   input  logic                  bus_rd_req,
   input  logic                  bus_wr_en,
   input  logic [DATA_WIDTH-1:0] bus_wr_data,
   output logic [DATA_WIDTH-1:0] bus_rd_data,
   output logic                  ready,
   output logic                  err_overrun,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_dq_out,
   output logic                  sram_dq_oe,
   input  logic [DATA_WIDTH-1:0] sram_dq_in,
   output logic                  sram_ce_n,
   output logic                  sram_oe_n,
   output logic                  sram_we_n
);

   localparam logic [3:0] c_cnt_load = 4'(WAIT_CYCLES - 1);

   sram_state_e           state_q,    state_d;
   logic [3:0]            cnt_q,      cnt_d;
   logic                  rd_req_q,   rd_req_d;
   logic                  ready_q,    ready_d;
   logic                  err_q,      err_d;
   logic [DATA_WIDTH-1:0] rd_data_q,  rd_data_d;
   logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
   logic [DATA_WIDTH-1:0] dq_out_q,   dq_out_d;
   logic                  dq_oe_q,    dq_oe_d;
   logic                  ce_n_q,     ce_n_d;
   logic                  oe_n_q,     oe_n_d;
   logic                  we_n_q,     we_n_d;

   logic                  w_rd_start;
   logic                  w_wr_start;

   // Edge detect is inlined so a read is launched in the very cycle after the
   // rising edge; an extra register stage would shift the ready timing.
   assign w_rd_start = bus_rd_req & ~rd_req_q & cs;
   assign w_wr_start = bus_wr_en & cs;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_req_d  = bus_rd_req;
      ready_d   = ready_q;
      err_d     = err_q;
      rd_data_d = rd_data_q;
      addr_d    = addr_q;
      dq_out_d  = dq_out_q;
      dq_oe_d   = dq_oe_q;
      ce_n_d    = ce_n_q;
      oe_n_d    = oe_n_q;
      we_n_d    = we_n_q;

      case (state_q)
         SRAM_IDLE: begin
            // Write has priority; a simultaneous read is dropped and flagged.
            if (w_wr_start) begin
               state_d  = SRAM_WR_SETUP;
               addr_d   = bus_addr;
               dq_out_d = bus_wr_data;
               dq_oe_d  = 1'b1;
               ce_n_d   = 1'b0;
               we_n_d   = 1'b1;
               ready_d  = 1'b0;
               if (w_rd_start) begin
                  err_d = 1'b1;
               end
            end else if (w_rd_start) begin
               state_d = SRAM_RD_ACCESS;
               addr_d  = bus_addr;
               cnt_d   = c_cnt_load;
               ce_n_d  = 1'b0;
               oe_n_d  = 1'b0;
               ready_d = 1'b0;
            end
         end
         SRAM_RD_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = SRAM_RD_CAPTURE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         SRAM_RD_CAPTURE: begin
            // oe_n has been low for WAIT_CYCLES+1 cycles; the pad data is settled.
            rd_data_d = sram_dq_in;
            ready_d   = 1'b1;
            ce_n_d    = 1'b1;
            oe_n_d    = 1'b1;
            state_d   = SRAM_IDLE;
         end
         SRAM_WR_SETUP: begin
            state_d = SRAM_WR_PULSE;
            we_n_d  = 1'b0;
            cnt_d   = c_cnt_load;
         end
         SRAM_WR_PULSE: begin
            if (cnt_q == 4'd0) begin
               state_d = SRAM_WR_HOLD;
               we_n_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         SRAM_WR_HOLD: begin
            // Address and data stay driven one cycle past we_n rising.
            state_d = SRAM_IDLE;
            dq_oe_d = 1'b0;
            ce_n_d  = 1'b1;
            ready_d = 1'b1;
         end
         default: begin
            state_d = SRAM_IDLE;
            dq_oe_d = 1'b0;
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
            ready_d = 1'b1;
         end
      endcase

      if ((state_q != SRAM_IDLE) && (w_rd_start || w_wr_start)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         state_q   <= SRAM_IDLE;
         cnt_q     <= 4'd0;
         rd_req_q  <= 1'b0;
         ready_q   <= 1'b1;
         err_q     <= 1'b0;
         rd_data_q <= '0;
         addr_q    <= '0;
         dq_out_q  <= '0;
         dq_oe_q   <= 1'b0;
         ce_n_q    <= 1'b1;
         oe_n_q    <= 1'b1;
         we_n_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_req_q  <= rd_req_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
         rd_data_q <= rd_data_d;
         addr_q    <= addr_d;
         dq_out_q  <= dq_out_d;
         dq_oe_q   <= dq_oe_d;
         ce_n_q    <= ce_n_d;
         oe_n_q    <= oe_n_d;
         we_n_q    <= we_n_d;
      end
   end

   assign bus_rd_data = rd_data_q;
   assign ready       = ready_q;
   assign err_overrun = err_q;
   assign sram_addr   = addr_q;
   assign sram_dq_out = dq_out_q;
   assign sram_dq_oe  = dq_oe_q;
   assign sram_ce_n   = ce_n_q;
   assign sram_oe_n   = oe_n_q;
   assign sram_we_n   = we_n_q;

endmodule : sram_bus_responder
`default_nettype wire

// File: tb/tb_sram_bus_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sram_bus_responder                                        |
// | Description : Self-checking bench. Four responders (W = 2, 4, 1, 15) share |
// |               the CPU bus; only the selected one sees cs. An async SRAM    |
// |               model and a reference memory supply the expected data.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sram_bus_responder;
   import sram_bus_responder_pkg::*;

   localparam int N_DUT = 4;

   function automatic int w_of(input int i);
      case (i)
         0:       return 2;
         1:       return 4;
         2:       return 1;
         default: return 15;
      endcase
   endfunction

   logic        sys_clk = 1'b0;
   logic        reset_n;
   logic        cs_en;
   logic        cs;
   logic [15:0] bus_addr;
   logic        bus_rd_req;
   logic        bus_wr_en;
   logic [7:0]  bus_wr_data;
   logic [7:0]  sram_dq_in = 8'h00;
   int          act;

   logic [7:0]  rd_data_a [N_DUT];
   logic        ready_a   [N_DUT];
   logic        err_a     [N_DUT];
   logic [15:0] saddr_a   [N_DUT];
   logic [7:0]  dqo_a     [N_DUT];
   logic        dqoe_a    [N_DUT];
   logic        ce_a      [N_DUT];
   logic        oe_a      [N_DUT];
   logic        we_a      [N_DUT];
   logic        cs_a      [N_DUT];

   logic [7:0]  bus_rd_data;
   logic        ready, err_overrun, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
   logic [15:0] sram_addr;
   logic [7:0]  sram_dq_out;

   int n_chk;
   int n_fail;

   always #5 sys_clk = ~sys_clk;

   assign cs = cs_en & sram_win_hit(bus_addr);

   for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
      assign cs_a[gi] = cs && (act == gi);
      sram_bus_responder #(
         .ADDR_WIDTH (16),
         .DATA_WIDTH (8),
         .WAIT_CYCLES(w_of(gi))
      ) u_dut (
         .sys_clk    (sys_clk),
         .reset_n    (reset_n),
         .cs         (cs_a[gi]),
         .bus_addr   (bus_addr),
         .bus_rd_req (bus_rd_req),
         .bus_wr_en  (bus_wr_en),
         .bus_wr_data(bus_wr_data),
         .bus_rd_data(rd_data_a[gi]),
         .ready      (ready_a[gi]),
         .err_overrun(err_a[gi]),
         .sram_addr  (saddr_a[gi]),
         .sram_dq_out(dqo_a[gi]),
         .sram_dq_oe (dqoe_a[gi]),
         .sram_dq_in (sram_dq_in),
         .sram_ce_n  (ce_a[gi]),
         .sram_oe_n  (oe_a[gi]),
         .sram_we_n  (we_a[gi])
      );
   end

   // The selected responder drives the SRAM pins and the CPU return path.
   always_comb begin
      bus_rd_data = rd_data_a[act];
      ready       = ready_a[act];
      err_overrun = err_a[act];
      sram_addr   = saddr_a[act];
      sram_dq_out = dqo_a[act];
      sram_dq_oe  = dqoe_a[act];
      sram_ce_n   = ce_a[act];
      sram_oe_n   = oe_a[act];
      sram_we_n   = we_a[act];
   end

   // Power-up contents of the SRAM: a fixed address hash (0x1234 -> 0xA5).
   function automatic logic [7:0] dflt(input logic [15:0] a);
      return a[15:8] ^ a[7:0] ^ 8'h83;
   endfunction

   // Asynchronous SRAM model: a write commits on we_n rising while ce_n is low.
   logic [7:0] sram_mem [int];
   logic       prev_we_n  = 1'b1;
   bit         contention = 1'b0;
   always @(negedge sys_clk) begin
      if (sram_dq_oe && !sram_oe_n) contention = 1'b1;
      if (!prev_we_n && sram_we_n && !sram_ce_n && sram_dq_oe)
         sram_mem[int'(sram_addr)] = sram_dq_out;
      prev_we_n = sram_we_n;
      if (!sram_ce_n && !sram_oe_n)
         sram_dq_in = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : dflt(sram_addr);
      else
         sram_dq_in = 8'h00;
   end

   // Reference memory: what the CPU should read back given the writes issued.
   logic [7:0] ref_mem [int];
   function automatic logic [7:0] ref_rd(input logic [15:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
   endfunction

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; cs_en = 1'b0; bus_rd_req = 1'b0; bus_wr_en = 1'b0;
      tick(); tick();
      reset_n = 1'b1; cs_en = 1'b1;
      tick();
   endtask

   // Issue a read; k counts cycles after the start cycle T.
   task automatic do_read(input logic [15:0] a, output logic [7:0] d,
                          output int rlow, output int oelow, output int oefirst, output bit to);
      cs_en = 1'b1; bus_addr = a; bus_rd_req = 1'b1;
      rlow = 0; oelow = 0; oefirst = -1; to = 1'b1; d = 8'h00;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (k == 1) bus_rd_req = 1'b0;
         if (!sram_oe_n) begin oelow++; if (oefirst < 0) oefirst = k; end
         if (ready) begin d = bus_rd_data; to = 1'b0; break; end
         rlow++;
      end
   endtask

   // Issue a write; optionally raise rd_req with it or pulse it at cycle poke_at.
   task automatic do_write(input logic [15:0] a, input logic [7:0] d, input bit rd_with,
                           input int poke_at, output int rlow, output int welow,
                           output int wefirst, output int oecnt, output int oenlow,
                           output bit dqoe_end, output bit to);
      cs_en = 1'b1; bus_addr = a; bus_wr_data = d; bus_wr_en = 1'b1; bus_rd_req = rd_with;
      rlow = 0; welow = 0; wefirst = -1; oecnt = 0; oenlow = 0; dqoe_end = 1'b1; to = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (k == 1) begin
            bus_wr_en   = 1'b0;
            bus_addr    = 16'($urandom_range(0, 32'h8FFF));
            bus_wr_data = 8'($urandom);
         end
         bus_rd_req = (k == poke_at);
         if (!sram_we_n) begin welow++; if (wefirst < 0) wefirst = k; end
         if (!sram_oe_n) oenlow++;
         if (ready) begin dqoe_end = sram_dq_oe; to = 1'b0; break; end
         if (sram_dq_oe) oecnt++;
         rlow++;
      end
   endtask

   task automatic test_reset();
      act = 0;
      do_reset();
      n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
      n_chk++; if (bus_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", bus_rd_data); end
      n_chk++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_overrun); end
      n_chk++; if ({sram_addr, sram_dq_out, sram_dq_oe} !== 25'h0) begin n_fail++;
         $display("FAIL reset_addr_data: got %h/%h/%b want 0", sram_addr, sram_dq_out, sram_dq_oe); end
      n_chk++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin n_fail++;
         $display("FAIL reset_strobes: got %b want 111", {sram_ce_n, sram_oe_n, sram_we_n}); end
   endtask

   task automatic test_read();
      logic [7:0] d; int rl, ol, of; bit to;
      act = 0;
      do_read(16'h1234, d, rl, ol, of, to);
      n_chk++; if (to) begin n_fail++; $display("FAIL read_timeout: ready never returned"); end
      n_chk++; if (d !== 8'hA5) begin n_fail++; $display("FAIL read_data: got %h want a5", d); end
      n_chk++; if (rl !== 3) begin n_fail++; $display("FAIL read_ready_low: got %0d want 3", rl); end
      n_chk++; if (ol !== 3 || of !== 1) begin n_fail++; $display("FAIL read_oe_window: got %0d from T+%0d want 3 from T+1", ol, of); end
   endtask

   task automatic test_write();
      logic [7:0] d; int rl, wl, wf, oc, onl, orl, ol, of; bit dqe, to, rto;
      act = 0;
      do_write(16'h8FFF, 8'h3C, 1'b0, 0, rl, wl, wf, oc, onl, dqe, to);
      ref_mem[int'(16'h8FFF)] = 8'h3C;
      n_chk++; if (to) begin n_fail++; $display("FAIL write_timeout: ready never returned"); end
      n_chk++; if (wl !== 2 || wf !== 2) begin n_fail++; $display("FAIL write_we_pulse: got %0d from T+%0d want 2 from T+2", wl, wf); end
      n_chk++; if (oc !== 4 || dqe !== 1'b0) begin n_fail++; $display("FAIL write_dq_oe: got %0d cycles end=%b want 4 end=0", oc, dqe); end
      n_chk++; if (rl !== 4) begin n_fail++; $display("FAIL write_ready_low: got %0d want 4", rl); end
      n_chk++; if (onl !== 0) begin n_fail++; $display("FAIL write_oe_n: got %0d low cycles want 0", onl); end
      do_read(16'h8FFF, d, orl, ol, of, rto);
      n_chk++; if (rto || d !== 8'h3C) begin n_fail++; $display("FAIL write_readback: got %h want 3c", d); end
      n_chk++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL write_err: got %b want 0", err_overrun); end
   endtask

   task automatic test_collision();
      logic [7:0] d; int rl, wl, wf, oc, onl, orl, ol, of; bit dqe, to, rto;
      act = 0;
      do_write(16'h0010, 8'h77, 1'b1, 0, rl, wl, wf, oc, onl, dqe, to);
      ref_mem[int'(16'h0010)] = 8'h77;
      n_chk++; if (to || onl !== 0 || wl !== 2) begin n_fail++;
         $display("FAIL collision_write_only: oe_low=%0d we_low=%0d want 0/2", onl, wl); end
      n_chk++; if (err_overrun !== 1'b1) begin n_fail++; $display("FAIL collision_err: got %b want 1", err_overrun); end
      do_read(16'h0010, d, orl, ol, of, rto);
      n_chk++; if (rto || d !== 8'h77) begin n_fail++; $display("FAIL collision_readback: got %h want 77", d); end
      n_chk++; if (err_overrun !== 1'b1) begin n_fail++; $display("FAIL collision_err_sticky: got %b want 1", err_overrun); end
   endtask

   task automatic test_overrun_during_write();
      logic [7:0] d; int rl, wl, wf, oc, onl, orl, ol, of; bit dqe, to, rto;
      act = 0;
      do_reset();
      n_chk++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_cleared: got %b want 0", err_overrun); end
      do_write(16'h2222, 8'h5E, 1'b0, 2, rl, wl, wf, oc, onl, dqe, to);
      ref_mem[int'(16'h2222)] = 8'h5E;
      n_chk++; if (err_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_err: got %b want 1", err_overrun); end
      n_chk++; if (to || rl !== 4 || wl !== 2 || onl !== 0) begin n_fail++;
         $display("FAIL overrun_write_shape: ready_low=%0d we_low=%0d oe_low=%0d want 4/2/0", rl, wl, onl); end
      do_read(16'h2222, d, orl, ol, of, rto);
      n_chk++; if (rto || d !== 8'h5E) begin n_fail++; $display("FAIL overrun_readback: got %h want 5e", d); end
   endtask

   task automatic test_cs_low();
      logic [7:0] d; int orl, ol, of, rlow, celow, welow; bit rto;
      act = 0;
      do_reset();
      do_read(16'h8FFF, d, orl, ol, of, rto);
      cs_en = 1'b0; bus_addr = 16'h8FFF; bus_wr_data = 8'h11; bus_rd_req = 1'b1; bus_wr_en = 1'b1;
      rlow = 0; celow = 0; welow = 0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         bus_wr_en = 1'b0;
         if (!ready) rlow++;
         if (!sram_ce_n || sram_dq_oe) celow++;
         if (!sram_we_n || !sram_oe_n) welow++;
      end
      bus_rd_req = 1'b0;
      tick();
      n_chk++; if (rlow !== 0 || celow !== 0 || welow !== 0) begin n_fail++;
         $display("FAIL cs_low_activity: ready_low=%0d ce=%0d strobe=%0d want 0", rlow, celow, welow); end
      n_chk++; if (bus_rd_data !== 8'h3C) begin n_fail++; $display("FAIL cs_low_rd_data: got %h want 3c", bus_rd_data); end
      n_chk++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL cs_low_err: got %b want 0", err_overrun); end
      do_read(16'h8FFF, d, orl, ol, of, rto);
      n_chk++; if (rto || d !== ref_rd(16'h8FFF)) begin n_fail++; $display("FAIL cs_low_mem: got %h want %h", d, ref_rd(16'h8FFF)); end
   endtask

   task automatic test_reset_mid_write();
      logic [7:0] d; int orl, ol, of; bit rto;
      act = 1;
      cs_en = 1'b1; bus_addr = 16'h0420; bus_wr_data = 8'h99; bus_wr_en = 1'b1;
      tick();
      bus_wr_en = 1'b0;
      tick();
      n_chk++; if (sram_we_n !== 1'b0) begin n_fail++; $display("FAIL abort_pulse_started: we_n got %b want 0", sram_we_n); end
      reset_n = 1'b0;
      tick();
      n_chk++; if ({sram_we_n, sram_ce_n, sram_dq_oe, ready} !== 4'b1101) begin n_fail++;
         $display("FAIL abort_outputs: we/ce/dq_oe/ready got %b want 1101", {sram_we_n, sram_ce_n, sram_dq_oe, ready}); end
      reset_n = 1'b1;
      tick();
      do_read(16'h0420, d, orl, ol, of, rto);
      n_chk++; if (rto || d !== ref_rd(16'h0420)) begin n_fail++; $display("FAIL abort_mem: got %h want %h", d, ref_rd(16'h0420)); end
      n_chk++; if (orl !== 5) begin n_fail++; $display("FAIL abort_w4_read_low: got %0d want 5", orl); end
   endtask

   task automatic test_wait_sweep();
      logic [7:0] d, wd; logic [15:0] a; int w, rl, wl, wf, oc, onl, orl, ol, of; bit dqe, to, rto;
      for (int i = 2; i < N_DUT; i++) begin
         act = i; w = w_of(i);
         a = 16'($urandom_range(0, 32'h8FFF)); wd = 8'($urandom);
         do_write(a, wd, 1'b0, 0, rl, wl, wf, oc, onl, dqe, to);
         ref_mem[int'(a)] = wd;
         n_chk++; if (to || rl !== w + 2 || wl !== w) begin n_fail++;
            $display("FAIL sweep_write W=%0d: ready_low=%0d we_low=%0d want %0d/%0d", w, rl, wl, w + 2, w); end
         do_read(a, d, orl, ol, of, rto);
         n_chk++; if (rto || orl !== w + 1 || d !== wd) begin n_fail++;
            $display("FAIL sweep_read W=%0d: ready_low=%0d data=%h want %0d/%h", w, orl, d, w + 1, wd); end
      end
   endtask

   task automatic test_random();
      logic [15:0] pool [6];
      logic [15:0] a; logic [7:0] d, wd;
      int w, rl, wl, wf, oc, onl, ol, of; bit dqe, to;
      do_reset();
      for (int i = 0; i < 6; i++) pool[i] = 16'($urandom_range(0, int'(SRAM_WIN_LAST)));
      for (int n = 0; n < 40; n++) begin
         act = int'($urandom_range(0, N_DUT - 1)); w = w_of(act);
         a = pool[$urandom_range(0, 5)];
         if ($urandom_range(0, 1) == 1) begin
            wd = 8'($urandom);
            do_write(a, wd, 1'b0, 0, rl, wl, wf, oc, onl, dqe, to);
            ref_mem[int'(a)] = wd;
            n_chk++; if (to || rl !== w + 2 || wl !== w || wf !== 2) begin n_fail++;
               $display("FAIL rand_write #%0d W=%0d: ready_low=%0d we_low=%0d first=%0d", n, w, rl, wl, wf); end
         end else begin
            do_read(a, d, rl, ol, of, to);
            n_chk++; if (to || rl !== w + 1 || d !== ref_rd(a)) begin n_fail++;
               $display("FAIL rand_read #%0d W=%0d a=%h: data=%h want %h ready_low=%0d", n, w, a, d, ref_rd(a), rl); end
         end
      end
      for (int i = 0; i < N_DUT; i++) begin
         n_chk++; if (err_a[i] !== 1'b0) begin n_fail++; $display("FAIL rand_err dut%0d: got %b want 0", i, err_a[i]); end
      end
      n_chk++; if (contention) begin n_fail++; $display("FAIL dq_contention: dq_oe seen with oe_n low"); end
   endtask

   initial begin
      n_chk = 0; n_fail = 0; act = 0;
      reset_n = 1'b0; cs_en = 1'b0; bus_addr = 16'h0000;
      bus_rd_req = 1'b0; bus_wr_en = 1'b0; bus_wr_data = 8'h00;
      test_reset();
      test_read();
      test_write();
      test_collision();
      test_overrun_during_write();
      test_cs_low();
      test_reset_mid_write();
      test_wait_sweep();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_sram_bus_responder
`default_nettype wire
